// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Brief   : Core-wide constants and the IF/ID pipeline record shared with decode.
// Revision: 1.0
// ============================================================================
package cpu_pkg;

    localparam int unsigned CPU_XLEN      = 32;
    localparam logic [31:0] CPU_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] CPU_NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic                valid;
        logic [CPU_XLEN-1:0] pc;
        logic [CPU_XLEN-1:0] pc4;
        logic [31:0]         instr;
    } if_id_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_stage_if
// Brief   : Instruction-memory bus between the fetch stage and the memory.
// Revision: 1.0
// ============================================================================
interface instr_fetch_stage_if #(
    parameter int unsigned XLEN = cpu_pkg::CPU_XLEN
);
    logic [XLEN-1:0] imem_addr_o;
    logic [31:0]     imem_instr_i;

    modport master (
        output imem_addr_o,
        input  imem_instr_i
    );

    modport slave (
        input  imem_addr_o,
        output imem_instr_i
    );
endinterface
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module  : if_id_reg
// Brief   : IF/ID pipeline register with reset, flush and hold controls.
// Revision: 1.0
// ============================================================================
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = CPU_NOP_INSTR
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic hold,
    input  wire logic flush,
    input  if_id_t    d,
    output if_id_t    q
);

    if_id_t r_q;

    // Flush wins over hold; pc/pc4 are left alone on flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q.valid <= 1'b0;
            r_q.pc    <= '0;
            r_q.pc4   <= '0;
            r_q.instr <= NOP_INSTR;
        end else if (flush) begin
            r_q.valid <= 1'b0;
            r_q.instr <= NOP_INSTR;
        end else if (!hold) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_stage
// Brief   : IF stage: PC register, imem addressing, IF/ID capture, stall and
//           redirect/flush. Define IF_PERF_CNT_EN to add fetch/stall/flush
//           performance counters.
// Revision: 1.0
// ============================================================================
module instr_fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN      = CPU_XLEN,   // must match CPU_XLEN (if_id_t width)
    parameter logic [31:0] RESET_PC  = CPU_RESET_PC,
    parameter logic [31:0] NOP_INSTR = CPU_NOP_INSTR
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               stall_i,
    input  wire logic               redirect_i,
    input  wire logic [XLEN-1:0]    redirect_pc_i,
    instr_fetch_stage_if.master     imem,
    output logic                    id_valid_o,
    output logic [XLEN-1:0]         id_pc_o,
    output logic [XLEN-1:0]         id_pc4_o,
    output logic [31:0]             id_instr_o,
    output logic                    misalign_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]             perf_fetch_o,
    output logic [31:0]             perf_stall_o,
    output logic [31:0]             perf_flush_o
`endif
);

    logic [XLEN-1:0] r_pc;
    logic            r_misalign;
    logic [XLEN-1:0] w_pc4;
    logic            w_advance;
    logic            w_stall_only;
    if_id_t          w_if_id_d;
    if_id_t          w_if_id_q;

    assign w_pc4        = r_pc + XLEN'(4);
    assign w_advance    = !redirect_i && !stall_i;
    assign w_stall_only = !redirect_i && stall_i;

    // Redirect targets are forced word-aligned so the pc[1:0]==0 invariant holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= XLEN'(RESET_PC);
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
            if (redirect_i) begin
                r_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
            end else if (!stall_i) begin
                r_pc <= w_pc4;
            end
        end
    end

    assign imem.imem_addr_o = r_pc;

    always_comb begin
        w_if_id_d.valid = 1'b1;
        w_if_id_d.pc    = r_pc;
        w_if_id_d.pc4   = w_pc4;
        w_if_id_d.instr = imem.imem_instr_i;
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk   (clk),
        .reset (reset),
        .hold  (stall_i),
        .flush (redirect_i),
        .d     (w_if_id_d),
        .q     (w_if_id_q)
    );

    assign id_valid_o = w_if_id_q.valid;
    assign id_pc_o    = w_if_id_q.pc;
    assign id_pc4_o   = w_if_id_q.pc4;
    assign id_instr_o = w_if_id_q.instr;
    assign misalign_o = r_misalign;

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    // Every non-reset cycle is exactly one of advance, stall-only or redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else if (redirect_i) begin
            r_perf_flush <= r_perf_flush + 32'd1;
        end else if (w_stall_only) begin
            r_perf_stall <= r_perf_stall + 32'd1;
        end else if (w_advance) begin
            r_perf_fetch <= r_perf_fetch + 32'd1;
        end
    end

    assign perf_fetch_o = r_perf_fetch;
    assign perf_stall_o = r_perf_stall;
    assign perf_flush_o = r_perf_flush;
`else
    logic w_unused_perf;
    assign w_unused_perf = w_advance ^ w_stall_only;
`endif

endmodule
`default_nettype wire
